// File: rtl/add_acc_stage_if.sv
// ---------------------------------------------------------------------------
// add_acc_stage_if
// Bundles the sample input port, the result output port and the synchronous
// clear of add_acc_stage.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds valid and its data
// stable until that transfer. ready may be low without valid being high.
//
// Signals
//   clr        producer -> stage  synchronous clear of the current window
//   in_valid   producer -> stage  sample valid
//   in_ready   stage -> producer  stage can take a sample
//   in_data    producer -> stage  sample, unsigned, WIDTH bits
//   out_valid  stage -> consumer  result valid
//   out_ready  consumer -> stage  consumer accepts the result
//   out_sum    stage -> consumer  accumulated sum, WIDTH bits
//   out_co     stage -> consumer  overflow seen in the window
//   out_cnt    stage -> consumer  samples accepted in the current window
//
// Modports
//   master : the side that supplies samples and consumes results
//   slave  : the accumulating stage itself
// ---------------------------------------------------------------------------
interface add_acc_stage_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_co;
    logic [CNT_W-1:0] out_cnt;

    modport master (
        output clr, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_co, out_cnt
    );

    modport slave (
        input  clr, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_co, out_cnt
    );
endinterface

// File: rtl/add_acc_stage.sv
// ---------------------------------------------------------------------------
// add_acc_stage
// Accumulating register stage feeding a WIDTH-bit adder. The running sum is
// the adder A operand, the accepted sample is the B operand (carry-in 0), and
// the WIDTH+1-bit result is registered back. After N_SAMPLES accepted samples
// the total is presented on the output port until the consumer takes it.
//
// Parameters
//   WIDTH      data / accumulator / sum width (equals the adder width)
//   N_SAMPLES  samples per result, 2..255
//   CNT_W      sample counter width, 2**CNT_W > N_SAMPLES
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   bus        add_acc_stage_if.slave: clr, sample input, result output
//   dbg_state  current FSM state (0 = ACC, 1 = EMIT)
//
// Configuration
//   ADD_ACC_SAT_EN  defined: any add that carries saturates the accumulator
//                   to all ones for the rest of the window.
//                   undefined: the accumulator wraps modulo 2**WIDTH.
//   In both builds out_co is the sticky OR of every carry in the window, and
//   the handshake, latency and FSM are identical.
//
// Edge priority: rst, then clr, then normal operation.
// ---------------------------------------------------------------------------
module add_acc_stage #(
    parameter int WIDTH     = 8,
    parameter int N_SAMPLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    add_acc_stage_if.slave       bus,
    output logic                 dbg_state
);

    typedef enum logic {
        ACC  = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic             sticky_co;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             co_q;

    // Adder operands: A = running sum, B = incoming sample, CI = 0.
    logic [WIDTH:0]   add_res;
    logic [WIDTH-1:0] acc_next;
    logic             co_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             last_sample;

    assign add_res = {1'b0, acc} + {1'b0, bus.in_data};

`ifdef ADD_ACC_SAT_EN
    // Once saturated, later adds either carry again or add zero, so the
    // accumulator stays at all ones without an extra flag.
    assign acc_next = add_res[WIDTH] ? {WIDTH{1'b1}} : add_res[WIDTH-1:0];
`else
    assign acc_next = add_res[WIDTH-1:0];
`endif

    assign co_next     = sticky_co | add_res[WIDTH];
    assign cnt_inc     = cnt + CNT_W'(1);
    assign last_sample = (cnt_inc == CNT_W'(N_SAMPLES));

    // in_ready is combinational on rst and clr so a sample offered in a
    // reset or clear cycle is visibly refused rather than silently dropped.
    assign bus.in_ready = (state == ACC) & ~rst & ~bus.clr;
    assign accept       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            sticky_co <= 1'b0;
            cnt       <= '0;
            sum_q     <= '0;
            co_q      <= 1'b0;
        end else if (bus.clr) begin
            // Drops the window; in EMIT this also discards the pending
            // result. The last presented sum/co stay on the output.
            state     <= ACC;
            acc       <= '0;
            sticky_co <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        acc       <= acc_next;
                        sticky_co <= co_next;
                        cnt       <= cnt_inc;
                        if (last_sample) begin
                            state <= EMIT;
                            sum_q <= acc_next;
                            co_q  <= co_next;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        state     <= ACC;
                        acc       <= '0;
                        sticky_co <= 1'b0;
                        cnt       <= '0;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

    assign bus.out_valid = (state == EMIT);
    assign bus.out_sum   = sum_q;
    assign bus.out_co    = co_q;
    assign bus.out_cnt   = cnt;
    assign dbg_state     = state;

endmodule
